// File: rtl/uop_scheduler.sv
// Commit-port merger: compacts up to NRET retiring uops per cycle into a FIFO and
// serializes them one per cycle. Optional drop counter enabled by MURE_SCHED_DROP_CNT_EN.

package mure_pkg;
  localparam int unsigned XLEN      = 32;
  localparam int unsigned CAUSE_LEN = 6;
  localparam int unsigned ITYPE_LEN = 3;

  typedef struct packed {
    logic                 valid;
    logic [ITYPE_LEN-1:0] itype;
    logic                 compressed;
    logic [XLEN-1:0]      pc;
  } uop_entry_s;

  typedef struct packed {
    uop_entry_s           uop;
    logic [CAUSE_LEN-1:0] cause;
    logic [XLEN-1:0]      tval;
  } sched_entry_s;
endpackage

module uop_scheduler
  import mure_pkg::*;
#(
  parameter int unsigned NRET  = 2,
  parameter int unsigned DEPTH = 8
) (
  input  logic                            clk_i,
  input  logic                            rst_i,
  input  uop_entry_s [NRET-1:0]           uop_entry_i,
  input  logic [CAUSE_LEN-1:0]            cause_i,
  input  logic [XLEN-1:0]                 tval_i,
  input  logic                            ready_i,
  output uop_entry_s                      uop_entry_o,
  output logic [CAUSE_LEN-1:0]            cause_o,
  output logic [XLEN-1:0]                 tval_o,
  output logic                            ready_o,
  output logic                            overflow_o,
  output logic                            resync_o,
  output logic [15:0]                     drop_cnt_o
);

  localparam int unsigned PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W  = $clog2(DEPTH + 1);
  localparam int unsigned LANE_W = $clog2(NRET + 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    RESYNC = 2'd2
  } state_e;

  state_e              state_q, state_d;
  sched_entry_s        mem_q [DEPTH];
  logic [PTR_W-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]    count_q, count_d;
  logic [NRET-1:0]     lane_eff;
  sched_entry_s        lane_ent [NRET];
  sched_entry_s        slot [NRET];
  sched_entry_s        head;
  logic [LANE_W-1:0]   n_eff, n_enq, drop_n;
  logic                enq, deq, overflow_d, resync_d;

  // Lane qualification: everything above the first exception/interrupt is cut off
  always_comb begin
    logic cut, act, exc;
    cut   = 1'b0;
    act   = 1'b0;
    exc   = 1'b0;
    n_eff = '0;
    for (int k = 0; k < NRET; k++) begin
      exc = (uop_entry_i[k].itype == ITYPE_LEN'(1)) || (uop_entry_i[k].itype == ITYPE_LEN'(2));
      act = uop_entry_i[k].valid || exc;
      lane_eff[k]       = act && !cut;
      lane_ent[k].uop   = uop_entry_i[k];
      lane_ent[k].cause = exc ? cause_i : '0;
      lane_ent[k].tval  = exc ? tval_i : '0;
      if (lane_eff[k]) n_eff = n_eff + LANE_W'(1);
      if (exc) cut = 1'b1;
    end
  end

  // Compaction: slot j receives the j-th surviving lane in ascending index order
  always_comb begin
    int pos;
    pos = 0;
    for (int j = 0; j < NRET; j++) begin
      slot[j] = '0;
      pos     = 0;
      for (int k = 0; k < NRET; k++) begin
        if (lane_eff[k]) begin
          if (pos == j) slot[j] = lane_ent[k];
          pos++;
        end
      end
    end
  end

  assign ready_o = (CNT_W'(DEPTH) - count_q) >= CNT_W'(NRET);
  assign deq     = ready_i && (count_q != '0);

  always_comb begin
    state_d    = state_q;
    enq        = 1'b0;
    overflow_d = 1'b0;
    resync_d   = 1'b0;
    drop_n     = '0;
    case (state_q)
      IDLE, ACTIVE: begin
        if (n_eff != '0) begin
          if (ready_o) begin
            enq = 1'b1;
          end else begin
            overflow_d = 1'b1;
            drop_n     = n_eff;
          end
        end
      end
      RESYNC:  drop_n = n_eff;
      default: state_d = IDLE;
    endcase
    n_enq   = enq ? n_eff : '0;
    count_d = count_q + CNT_W'(n_enq) - CNT_W'(deq);
    if (state_q == RESYNC) begin
      if (count_d == '0) begin
        state_d  = IDLE;
        resync_d = 1'b1;
      end
    end else if (overflow_d) begin
      state_d = RESYNC;
    end else if (state_q == IDLE || state_q == ACTIVE) begin
      state_d = (count_d == '0) ? IDLE : ACTIVE;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_o <= 1'b0;
      resync_o   <= 1'b0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      overflow_o <= overflow_d;
      resync_o   <= resync_d;
      for (int k = 0; k < NRET; k++) begin
        if (LANE_W'(k) < n_enq) mem_q[wr_ptr_q + PTR_W'(k)] <= slot[k];
      end
      wr_ptr_q <= wr_ptr_q + PTR_W'(n_enq);
      if (deq) rd_ptr_q <= rd_ptr_q + PTR_W'(1);
    end
  end

  // Head is presented only when the FIFO holds something; otherwise all-zero
  assign head        = (count_q != '0) ? mem_q[rd_ptr_q] : '0;
  assign uop_entry_o = head.uop;
  assign cause_o     = head.cause;
  assign tval_o      = head.tval;

`ifdef MURE_SCHED_DROP_CNT_EN
  logic [15:0] drop_cnt_q;
  logic [16:0] drop_sum;

  assign drop_sum = {1'b0, drop_cnt_q} + 17'(drop_n);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) drop_cnt_q <= '0;
    else       drop_cnt_q <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
  end

  assign drop_cnt_o = drop_cnt_q;
`else
  logic unused_drop;
  assign unused_drop = ^drop_n;
  assign drop_cnt_o  = '0;
`endif

endmodule

// File: tb/tb_uop_scheduler.sv
// Self-checking bench for uop_scheduler: directed scenarios plus random traffic
// compared against a queue-based reference model.

module tb_uop_scheduler;
  import mure_pkg::*;

  localparam int unsigned NRET  = 2;
  localparam int unsigned DEPTH = 8;

  logic                  clk_i = 1'b0;
  logic                  rst_i;
  uop_entry_s [NRET-1:0] uop_entry_i;
  logic [CAUSE_LEN-1:0]  cause_i;
  logic [XLEN-1:0]       tval_i;
  logic                  ready_i;
  uop_entry_s            uop_entry_o;
  logic [CAUSE_LEN-1:0]  cause_o;
  logic [XLEN-1:0]       tval_o;
  logic                  ready_o;
  logic                  overflow_o;
  logic                  resync_o;
  logic [15:0]           drop_cnt_o;

  uop_scheduler #(.NRET(NRET), .DEPTH(DEPTH)) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .uop_entry_i (uop_entry_i),
    .cause_i     (cause_i),
    .tval_i      (tval_i),
    .ready_i     (ready_i),
    .uop_entry_o (uop_entry_o),
    .cause_o     (cause_o),
    .tval_o      (tval_o),
    .ready_o     (ready_o),
    .overflow_o  (overflow_o),
    .resync_o    (resync_o),
    .drop_cnt_o  (drop_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  // Reference model state
  sched_entry_s mq[$];
  bit           m_resync;
  bit           m_ovf;
  bit           m_rsp;
  int unsigned  m_drop;
  int           checks = 0;
  int           errors = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] exp_drop();
`ifdef MURE_SCHED_DROP_CNT_EN
    return (m_drop > 32'hFFFF) ? 16'hFFFF : m_drop[15:0];
`else
    return 16'h0;
`endif
  endfunction

  task automatic model_reset();
    mq.delete();
    m_resync = 1'b0;
    m_ovf    = 1'b0;
    m_rsp    = 1'b0;
    m_drop   = 0;
  endtask

  task automatic check_outputs();
    sched_entry_s h;
    h = '0;
    if (mq.size() > 0) h = mq[0];
    check("uop_entry", 64'(uop_entry_o), 64'(h.uop));
    check("cause", 64'(cause_o), 64'(h.cause));
    check("tval", 64'(tval_o), 64'(h.tval));
    check("ready", 64'(ready_o), 64'((DEPTH - mq.size()) >= NRET));
    check("overflow", 64'(overflow_o), 64'(m_ovf));
    check("resync", 64'(resync_o), 64'(m_rsp));
    check("drop_cnt", 64'(drop_cnt_o), 64'(exp_drop()));
  endtask

  // One clock of the model, from the rules: filter lanes, pop, then push or drop
  task automatic model_step();
    sched_entry_s eff[$];
    sched_entry_s e;
    bit was_rs;
    bit room;
    bit exc;
    was_rs = m_resync;
    room   = (DEPTH - mq.size()) >= NRET;
    for (int k = 0; k < NRET; k++) begin
      exc = (uop_entry_i[k].itype == 3'd1) || (uop_entry_i[k].itype == 3'd2);
      if (uop_entry_i[k].valid || exc) begin
        e.uop   = uop_entry_i[k];
        e.cause = exc ? cause_i : '0;
        e.tval  = exc ? tval_i : '0;
        eff.push_back(e);
        if (exc) break;
      end
    end
    m_ovf = 1'b0;
    m_rsp = 1'b0;
    if (mq.size() > 0 && ready_i) void'(mq.pop_front());
    if (!was_rs) begin
      if (eff.size() > 0) begin
        if (room) begin
          foreach (eff[i]) mq.push_back(eff[i]);
        end else begin
          m_drop   += eff.size();
          m_ovf    = 1'b1;
          m_resync = 1'b1;
        end
      end
    end else begin
      m_drop += eff.size();
      if (mq.size() == 0) begin
        m_rsp    = 1'b1;
        m_resync = 1'b0;
      end
    end
  endtask

  task automatic drive(input logic v0, input logic [2:0] t0, input logic [31:0] pc0,
                       input logic v1, input logic [2:0] t1, input logic [31:0] pc1,
                       input logic [CAUSE_LEN-1:0] c, input logic [XLEN-1:0] tv,
                       input logic rdy);
    uop_entry_i[0].valid      = v0;
    uop_entry_i[0].itype      = t0;
    uop_entry_i[0].compressed = 1'b0;
    uop_entry_i[0].pc         = pc0;
    uop_entry_i[1].valid      = v1;
    uop_entry_i[1].itype      = t1;
    uop_entry_i[1].compressed = 1'b0;
    uop_entry_i[1].pc         = pc1;
    cause_i = c;
    tval_i  = tv;
    ready_i = rdy;
  endtask

  // Called at a negedge with inputs set: check, advance model, move to next negedge
  task automatic cycle();
    #1;
    check_outputs();
    model_step();
    @(negedge clk_i);
  endtask

  task automatic idle(input logic rdy);
    drive(0, 0, 0, 0, 0, 0, 0, 0, rdy);
    cycle();
  endtask

  initial begin
    rst_i = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    model_reset();
    #1;
    check_outputs();
    @(negedge clk_i);
    rst_i = 1'b0;
    idle(1);

    // Two plain retirements in one cycle serialize over two cycles
    drive(1, 0, 32'h100, 1, 0, 32'h104, 0, 0, 1);
    cycle();
    check("pair_first_pc", 64'(uop_entry_o.pc), 64'h100);
    idle(1);
    check("pair_second_pc", 64'(uop_entry_o.pc), 64'h104);
    idle(1);
    check("pair_drained", 64'(uop_entry_o.valid), 64'h0);

    // Exception on lane 0 suppresses lane 1
    drive(0, 3'd1, 32'h200, 1, 0, 32'h204, 6'd2, 32'hDEAD, 1);
    cycle();
    check("exc_itype", 64'(uop_entry_o.itype), 64'h1);
    check("exc_cause", 64'(cause_o), 64'h2);
    check("exc_tval", 64'(tval_o), 64'hDEAD);
    idle(1);
    check("exc_lane1_gone", 64'(uop_entry_o), 64'h0);

    // Interrupt on lane 1 only
    drive(0, 0, 0, 0, 3'd2, 32'h300, 6'd7, 32'h0, 1);
    cycle();
    check("irq_itype", 64'(uop_entry_o.itype), 64'h2);
    check("irq_cause", 64'(cause_o), 64'h7);
    check("irq_valid", 64'(uop_entry_o.valid), 64'h0);
    idle(1);

    // Fill with downstream stalled until full, then one more pair overflows
    for (int i = 0; i < 4; i++) begin
      drive(1, 0, 32'h1000 + 32'(i * 8), 1, 0, 32'h1004 + 32'(i * 8), 0, 0, 0);
      cycle();
    end
    check("full_not_ready", 64'(ready_o), 64'h0);
    drive(1, 0, 32'h2000, 1, 0, 32'h2004, 0, 0, 0);
    cycle();
    check("ovf_pulse", 64'(overflow_o), 64'h1);
    // Drain while traffic continues; all of it is discarded until empty
    for (int i = 0; i < 10; i++) begin
      drive(1, 0, 32'h3000 + 32'(i * 8), 1, 0, 32'h3004 + 32'(i * 8), 0, 0, 1);
      cycle();
    end
    idle(1);

    // Random traffic with alternating backpressure phases
    for (int i = 0; i < 600; i++) begin
      int unsigned rp;
      logic [2:0]  t0, t1;
      rp = ((i / 40) % 2 == 0) ? 25 : 90;
      t0 = 3'($urandom_range(0, 9) > 7 ? $urandom_range(1, 3) : 0);
      t1 = 3'($urandom_range(0, 9) > 7 ? $urandom_range(1, 3) : 0);
      drive(1'($urandom_range(0, 9) < 6), t0, $urandom,
            1'($urandom_range(0, 9) < 6), t1, $urandom,
            CAUSE_LEN'($urandom), $urandom,
            1'($urandom_range(0, 99) < rp));
      cycle();
    end

    // Reset with entries buffered: outputs clear at once, no resync afterwards
    for (int i = 0; i < 3; i++) begin
      drive(1, 0, 32'h4000 + 32'(i * 8), 1, 0, 32'h4004 + 32'(i * 8), 0, 0, 0);
      cycle();
    end
    drive(0, 0, 0, 0, 0, 0, 0, 0, 1);
    #2;
    rst_i = 1'b1;
    model_reset();
    #1;
    check_outputs();
    @(negedge clk_i);
    rst_i = 1'b0;
    for (int i = 0; i < 4; i++) idle(1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
